// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan mux: slot indices and
// active-low segment patterns {a,b,c,d,e,f,g}.
package seg_pkg;

  typedef enum logic [1:0] {
    SLOT_S1  = 2'd0,
    SLOT_S2  = 2'd1,
    SLOT_SC1 = 2'd2,
    SLOT_SC2 = 2'd3
  } slot_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low one-hot digit enable for a slot; an[0] is the rightmost digit.
  function automatic logic [3:0] an_for(slot_t s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low seven-segment pattern; 10-15 show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Four-digit multiplexed display for countdown time and score, with
// frame-aligned input snapshots. Define SEG_BLINK_EN to blink 00 at time-up.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s1,
  input  logic [2:0] s2,
  input  logic [3:0] sc1,
  input  logic [3:0] sc2,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       time_up
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] refresh_cnt;
  slot_t         idx;
  logic [3:0]    sh_s1;
  logic [2:0]    sh_s2;
  logic [3:0]    sh_sc1;
  logic [3:0]    sh_sc2;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;
  logic          cnt_wrap;
  logic          frame_end;
  logic          time_zero;
  logic          blank;

  assign cnt_wrap  = (refresh_cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = cnt_wrap && (idx == SLOT_SC2);
  assign time_zero = (sh_s1 == 4'd0) && (sh_s2 == 3'd0);

  always_comb begin
    digit = sh_s1;
    case (idx)
      SLOT_S1:  digit = sh_s1;
      SLOT_S2:  digit = {1'b0, sh_s2};
      SLOT_SC1: digit = sh_sc1;
      SLOT_SC2: digit = sh_sc2;
      default:  digit = sh_s1;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_cnt;
  logic          phase;

  // Phase 0 is the dark half, so a fresh time-up starts with the digits off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (!time_zero) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  assign blank = ((idx == SLOT_SC2) && (sh_sc2 == 4'd0)) ||
                 (time_zero && !phase && ((idx == SLOT_S1) || (idx == SLOT_S2)));
`else
  assign blank = (idx == SLOT_SC2) && (sh_sc2 == 4'd0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx         <= SLOT_S1;
      sh_s1       <= 4'd9;
      sh_s2       <= 3'd5;
      sh_sc1      <= 4'd0;
      sh_sc2      <= 4'd0;
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      time_up     <= 1'b0;
    end else begin
      refresh_cnt <= cnt_wrap ? '0 : refresh_cnt + CW'(1);
      if (cnt_wrap) idx <= slot_t'(idx + 2'd1);
      // Inputs only enter at the 3->0 wrap so a frame never mixes old and new values.
      if (frame_end) begin
        sh_s1  <= s1;
        sh_s2  <= s2;
        sh_sc1 <= sc1;
        sh_sc2 <= sc2;
      end
      an      <= blank ? AN_OFF : an_for(idx);
      seg     <= blank ? SEG_BLANK : dec_seg;
      dp      <= ~(idx == SLOT_SC1);
      time_up <= time_zero;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux: directed steps plus random input
// churn, compared every clock against a frame-level reference model.
module tb_seg_display_mux;

  localparam int DIV   = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] s1 = 4'd0;
  logic [2:0] s2 = 3'd0;
  logic [3:0] sc1 = 4'd0;
  logic [3:0] sc2 = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       time_up;

  seg_display_mux #(
    .REFRESH_DIV  (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s1      (s1),
    .s2      (s2),
    .sc1     (sc1),
    .sc2     (sc2),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .time_up (time_up)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;

  // model state: edges since reset release, frame snapshot, start frame of a 00 run
  int e;
  int m_s1, m_s2, m_sc1, m_sc2;
  int zstart;

  function automatic logic [6:0] ref_pat(int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    e = 0;
    m_s1 = 9; m_s2 = 5; m_sc1 = 0; m_sc2 = 0;
    zstart = 0;
  endtask

  // One clock: derive expected outputs from slot/frame arithmetic, then check.
  task automatic tick();
    int slot, fo, value;
    bit zero, blank;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic edp, etu;
    @(posedge clk);
    e++;
    slot = ((e - 1) / DIV) % 4;
    fo   = (e - 1) / FRAME;
    zero = (m_s1 == 0) && (m_s2 == 0);
    blank = (slot == 3) && (m_sc2 == 0);
`ifdef SEG_BLINK_EN
    if (zero && slot < 2 && (((fo - zstart) / BF) % 2) == 0) blank = 1'b1;
`endif
    case (slot)
      0: value = m_s1;
      1: value = m_s2;
      2: value = m_sc1;
      default: value = m_sc2;
    endcase
    ean  = blank ? 4'b1111 : ~(4'b0001 << slot);
    eseg = blank ? 7'b1111111 : ref_pat(value);
    edp  = (slot == 2) ? 1'b0 : 1'b1;
    etu  = zero;
    if (e % FRAME == 0) begin
      if (!zero && s1 == 4'd0 && s2 == 3'd0) zstart = e / FRAME;
      m_s1 = s1; m_s2 = s2; m_sc1 = sc1; m_sc2 = sc2;
    end
    #1;
    check("an", an, ean);
    check("seg", seg, eseg);
    check("dp", dp, edp);
    check("time_up", time_up, etu);
  endtask

  task automatic tick_to(input int target);
    while (e < target) tick();
  endtask

  // Called just after a checked edge: reset lands mid-slot, away from any edge.
  task automatic reset_mid();
    #2;
    reset = 1'b1;
    #1;
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_dp", dp, 1'b1);
    check("rst_tu", time_up, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_an", an, 4'b1111);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    s1 = 4'd3; s2 = 3'd4; sc1 = 4'd7; sc2 = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    check("init_an", an, 4'b1111);
    check("init_seg", seg, 7'b1111111);
    check("init_dp", dp, 1'b1);
    check("init_tu", time_up, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // reset shadow 59 first, then the first snapshot appears in frame 1
    tick_to(1);
    check("first_slot0", seg, 7'b0000100);
    tick_to(5);
    check("first_slot1", seg, 7'b0100100);
    tick_to(17);
    check("scan_s1_an", an, 4'b1110);
    check("scan_s1_seg", seg, 7'b0000110);
    tick_to(21);
    check("scan_s2_seg", seg, 7'b1001100);
    s1 = 4'd5;
    tick_to(25);
    check("scan_sc1_an", an, 4'b1011);
    check("scan_sc1_dp", dp, 1'b0);
    check("scan_sc1_seg", seg, 7'b0001111);
    tick_to(29);
    check("scan_sc2_an", an, 4'b0111);
    check("scan_sc2_seg", seg, 7'b0010010);
    tick_to(33);
    check("midframe_s1", seg, 7'b0100100);

    sc2 = 4'd0; sc1 = 4'd5;
    tick_to(61);
    check("sc2_blank_an", an, 4'b1111);
    check("sc2_blank_seg", seg, 7'b1111111);

    s1 = 4'd0; s2 = 3'd0;
    tick_to(64);
    check("tu_before", time_up, 1'b0);
    tick_to(65);
    check("tu_after", time_up, 1'b1);
`ifdef SEG_BLINK_EN
    check("blink_dark_an", an, 4'b1111);
    check("blink_dark_seg", seg, 7'b1111111);
`else
    check("tu_steady_seg", seg, 7'b0000001);
`endif
    tick_to(97);
    check("tu_lit_an", an, 4'b1110);
    check("tu_lit_seg", seg, 7'b0000001);

    s1 = 4'hC;
    tick_to(113);
    check("dash_seg", seg, 7'b1111110);
    check("dash_tu", time_up, 1'b0);

    tick_to(121);
    reset_mid();
    tick_to(1);
    check("post_rst_s1", seg, 7'b0000100);
    tick_to(5);
    check("post_rst_s2", seg, 7'b0100100);

    // random churn, including zero-time runs and one more mid-frame reset
    for (int i = 0; i < 700; i++) begin
      tick();
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          s1 = 4'd0; s2 = 3'd0;
        end else begin
          s1 = 4'($urandom_range(0, 15));
          s2 = 3'($urandom_range(0, 7));
        end
        sc1 = 4'($urandom_range(0, 15));
        sc2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if (i == 350) reset_mid();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (>=2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 125, scan frames per blink half-period (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s1  input  4  seconds-ones BCD digit from the countdown timer.
REQ-006 SHALL have port s2  input  3  seconds-tens digit from the countdown timer.
REQ-007 SHALL have port sc1  input  4  score-ones BCD digit.
REQ-008 SHALL have port sc2  input  4  score-tens BCD digit.
REQ-009 SHALL have port an  output  4  active-low one-hot digit enables; an[0] is rightmost.
REQ-010 SHALL have port seg  output  7  active-low segments {a,b,c,d,e,f,g}.
REQ-011 SHALL have port dp  output  1  active-low decimal point.
REQ-012 SHALL have port time_up  output  1  high while the snapshot time is 00.

Function
REQ-013 SHALL count refresh counter 0..REFRESH_DIV-1, wrapping to 0; wrap advances digit index 0->1->2->3->0.
REQ-014 SHALL snapshot s1, s2, sc1, sc2 into shadow registers on the edge where the index goes 3->0; inputs never drive outputs directly (no tearing mid-frame).
REQ-015 SHALL map index 0=s1/an[0], 1=s2/an[1], 2=sc1/an[2], 3=sc2/an[3] from shadow values.
REQ-016 SHALL register an, seg, dp: they reflect a new index exactly 1 clk after the index update.
REQ-017 SHALL decode 0-9 to standard patterns (0=7'b0000001, 1=7'b1001111, 8=7'b0000000); values 10-15 SHALL show dash 7'b1111110.
REQ-018 SHALL blank slot 3 (an[3]=1, seg=7'b1111111) when shadow sc2==0; time digits never leading-zero blanked.
REQ-019 SHALL drive dp=0 only in slot 2 (score/time separator), else 1.
REQ-020 SHALL set time_up (registered) to (shadow s2==0 && shadow s1==0); it updates only at snapshot.
REQ-021 SHALL hold outputs steady if inputs change mid-frame; new values appear at next frame start.

Reset
REQ-022 SHALL on reset clear refresh counter, index, blink state to 0.
REQ-023 SHALL on reset load shadow s1=9, s2=5, sc1=0, sc2=0.
REQ-024 SHALL on reset drive an=4'b1111, seg=7'b1111111, dp=1, time_up=0; first lit slot (slot 0) appears 1 clk after reset release.
REQ-025 SHALL on reset mid-frame abandon the frame immediately; no partial snapshot.

Configuration
REQ-026 SHALL with SEG_BLINK_EN defined: frame counter counts completed frames; phase toggles every BLINK_FRAMES frames; while time_up=1 and phase off, slots 0 and 1 blanked (an bit 1, seg all 1); phase cleared when time_up=0.
REQ-027 SHALL without SEG_BLINK_EN: no frame counter/phase logic; time digits steady at 00 when time_up=1.

Structure
REQ-028 SHALL place segment pattern constants (digits, dash, blank), digit-index typedef and slot constants in shared package seg_pkg.
REQ-029 SHALL use one combinational sub-module bcd_to_seg (4-bit in, 7-bit active-low out, REQ-017 table).

Verification
REQ-030 SHALL check: REFRESH_DIV=4, s1=3,s2=4,sc1=7,sc2=2 -> an cycles 1110,1101,1011,0111 each 4 clk; seg=3,4,7,2 patterns; dp=0 only with an=1011.
REQ-031 SHALL check: change s1 3->5 while slot 1 active -> slot 0 shows 3 until next 3->0 wrap, then 5.
REQ-032 SHALL check: sc2=0, sc1=5 -> an[3] never low; slot 3 seg=1111111.
REQ-033 SHALL check: s1=0,s2=0 -> time_up=1 one clk after next snapshot; with SEG_BLINK_EN, BLINK_FRAMES=2, slots 0/1 dark 2 frames, lit 2 frames; without, steady 0000001.
REQ-034 SHALL check: reset asserted mid-slot 2 -> same-delta an=1111, seg=1111111, time_up=0; after release slot 0 shows 9, slot 1 shows 5.
REQ-035 SHALL check: s1=4'hC -> slot 0 seg=1111110 (dash).
